// File: rtl/alarm_bank.sv
// Multi-channel alarm unit: stamp storage with registered readback, tick-qualified
// stamp match with lowest-index priority, and a ring/pause/snooze sequencing FSM.
module alarm_bank #(
    parameter int NUM_ALARMS   = 4,
    parameter int IDX_W        = 2,
    parameter int STAMP_W      = 64,
    parameter int RING_ON      = 5,
    parameter int RING_OFF     = 10,
    parameter int RING_BURSTS  = 3,
    parameter int SNOOZE_TICKS = 300
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [STAMP_W-1:0] counter,
    input  logic               set,
    input  logic               clear,
    input  logic [IDX_W-1:0]   sel,
    input  logic [STAMP_W-1:0] set_stamp,
    input  logic               set_en,
    input  logic               cancel,
    input  logic               snooze,
    output logic [STAMP_W-1:0] sel_stamp,
    output logic               sel_en,
    output logic               ring,
    output logic [IDX_W-1:0]   ring_id,
    output logic               active
);

    // state  | meaning
    // IDLE   | no alarm in progress, ring_id holds last trigger
    // ON     | buzzer driven for RING_ON ticks
    // OFF    | pause of RING_OFF ticks between bursts
    // SNOOZE | silence for SNOOZE_TICKS, then bursts restart from zero
    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_SNOOZE} state_t;

    localparam int MAX_A   = (RING_ON > RING_OFF) ? RING_ON : RING_OFF;
    localparam int CNT_MAX = (MAX_A > SNOOZE_TICKS) ? MAX_A : SNOOZE_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BST_W   = $clog2(RING_BURSTS + 1);

    logic [STAMP_W-1:0]    stamp_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] en_q;
    logic [STAMP_W-1:0]    sel_stamp_q;
    logic                  sel_en_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d, tick_inc;
    logic [BST_W-1:0] burst_cnt_q, burst_cnt_d, burst_nxt;
    logic [IDX_W-1:0] ring_id_q, ring_id_d;
    logic             ring_q;

    logic             sel_ok;
    logic             any_hit;
    logic [IDX_W-1:0] winner;
    logic             kill;

    assign sel_ok = (int'(sel) < NUM_ALARMS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) stamp_q[i] <= '0;
            en_q        <= '0;
            sel_stamp_q <= '0;
            sel_en_q    <= 1'b0;
        end else begin
            if (sel_ok) begin
                if (clear) begin
                    stamp_q[sel] <= '0;
                    en_q[sel]    <= 1'b0;
                end else if (set) begin
                    stamp_q[sel] <= set_stamp;
                    en_q[sel]    <= set_en;
                end
                sel_stamp_q <= stamp_q[sel];
                sel_en_q    <= en_q[sel];
            end else begin
                sel_stamp_q <= '0;
                sel_en_q    <= 1'b0;
            end
        end
    end

    // Scan downward so the lowest matching index is the one left in winner.
    always_comb begin
        any_hit = 1'b0;
        winner  = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (tick && en_q[i] && (stamp_q[i] == counter)) begin
                any_hit = 1'b1;
                winner  = IDX_W'(i);
            end
        end
    end

    // Disarming the channel that is currently ringing stops the alarm.
    assign kill = (state_q != S_IDLE) && sel_ok && (sel == ring_id_q)
                  && (clear || (set && !set_en));

    assign tick_inc  = (tick_cnt_q == CNT_W'(CNT_MAX)) ? tick_cnt_q : tick_cnt_q + CNT_W'(1);
    assign burst_nxt = burst_cnt_q + BST_W'(1);

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        burst_cnt_d = burst_cnt_q;
        ring_id_d   = ring_id_q;
        if (cancel || kill) begin
            state_d     = S_IDLE;
            tick_cnt_d  = '0;
            burst_cnt_d = '0;
        end else if (any_hit) begin
            state_d     = S_ON;
            tick_cnt_d  = '0;
            burst_cnt_d = '0;
            ring_id_d   = winner;
        end else if (snooze && (state_q == S_ON || state_q == S_OFF)) begin
            state_d    = S_SNOOZE;
            tick_cnt_d = '0;
        end else if (tick) begin
            case (state_q)
                S_ON: begin
                    if (tick_cnt_q == CNT_W'(RING_ON - 1)) begin
                        tick_cnt_d  = '0;
                        burst_cnt_d = burst_nxt;
                        state_d     = (burst_nxt == BST_W'(RING_BURSTS)) ? S_IDLE : S_OFF;
                    end else begin
                        tick_cnt_d = tick_inc;
                    end
                end
                S_OFF: begin
                    if (tick_cnt_q == CNT_W'(RING_OFF - 1)) begin
                        tick_cnt_d = '0;
                        state_d    = S_ON;
                    end else begin
                        tick_cnt_d = tick_inc;
                    end
                end
                S_SNOOZE: begin
                    if (tick_cnt_q == CNT_W'(SNOOZE_TICKS - 1)) begin
                        tick_cnt_d  = '0;
                        burst_cnt_d = '0;
                        state_d     = S_ON;
                    end else begin
                        tick_cnt_d = tick_inc;
                    end
                end
                default: begin
                    tick_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            burst_cnt_q <= '0;
            ring_id_q   <= '0;
            ring_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            ring_id_q   <= ring_id_d;
            ring_q      <= (state_d == S_ON);
        end
    end

    assign sel_stamp = sel_stamp_q;
    assign sel_en    = sel_en_q;
    assign ring      = ring_q;
    assign ring_id   = ring_id_q;
    assign active    = (state_q != S_IDLE);

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: default build plus a 3-channel build sharing inputs
// so that an out-of-range channel select can be exercised.
module tb_alarm_bank;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic [63:0] counter;
    logic        set;
    logic        clear;
    logic [1:0]  sel;
    logic [63:0] set_stamp;
    logic        set_en;
    logic        cancel;
    logic        snooze;

    logic [63:0] sel_stamp, sel_stamp3;
    logic        sel_en, sel_en3;
    logic        ring, ring3;
    logic [1:0]  ring_id, ring_id3;
    logic        active, active3;

    int total;
    int passed;

    alarm_bank dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .counter(counter),
        .set(set), .clear(clear), .sel(sel), .set_stamp(set_stamp), .set_en(set_en),
        .cancel(cancel), .snooze(snooze),
        .sel_stamp(sel_stamp), .sel_en(sel_en), .ring(ring), .ring_id(ring_id), .active(active)
    );

    alarm_bank #(.NUM_ALARMS(3), .IDX_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .counter(counter),
        .set(set), .clear(clear), .sel(sel), .set_stamp(set_stamp), .set_en(set_en),
        .cancel(cancel), .snooze(snooze),
        .sel_stamp(sel_stamp3), .sel_en(sel_en3), .ring(ring3), .ring_id(ring_id3), .active(active3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input logic [63:0] st, input logic e);
        sel       = 2'(ch);
        set_stamp = st;
        set_en    = e;
        set       = 1'b1;
        cyc();
        set       = 1'b0;
    endtask

    task automatic tick_at(input logic [63:0] v);
        counter = v;
        tick    = 1'b1;
        cyc();
        tick    = 1'b0;
    endtask

    task automatic burst_pattern(input logic [63:0] base, input string tag);
        for (int k = 1; k <= 40; k++) begin
            cyc();
            tick_at(base + 64'(k));
            check({tag, "_ring"}, {63'd0, ring}, {63'd0, (k < 35) && ((k % 15) < 5)});
            check({tag, "_active"}, {63'd0, active}, {63'd0, (k < 35)});
        end
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst_n = 1'b0; tick = 1'b0; counter = '0; set = 1'b0; clear = 1'b0;
        sel = '0; set_stamp = '0; set_en = 1'b0; cancel = 1'b0; snooze = 1'b0;

        // reset and readback of every channel
        cyc(); cyc();
        rst_n = 1'b1;
        check("rst_ring", {63'd0, ring}, 64'd0);
        check("rst_active", {63'd0, active}, 64'd0);
        check("rst_ring_id", {62'd0, ring_id}, 64'd0);
        for (int c = 0; c < 4; c++) begin
            sel = 2'(c);
            cyc();
            check("rst_stamp", sel_stamp, 64'd0);
            check("rst_en", {63'd0, sel_en}, 64'd0);
        end

        // single alarm on ch2, readback latency, full ring pattern
        wr(2, 64'd100, 1'b1);
        check("rb_latency", sel_stamp, 64'd0);
        cyc();
        check("rb_stamp", sel_stamp, 64'd100);
        check("rb_en", {63'd0, sel_en}, 64'd1);
        for (int v = 91; v <= 99; v++) tick_at(64'(v));
        check("pre_match_ring", {63'd0, ring}, 64'd0);
        tick_at(64'd100);
        check("match_ring", {63'd0, ring}, 64'd1);
        check("match_id", {62'd0, ring_id}, 64'd2);
        check("match_active", {63'd0, active}, 64'd1);
        burst_pattern(64'd100, "burst");
        check("idle_id_hold", {62'd0, ring_id}, 64'd2);

        // two channels on the same stamp: lowest wins; disabled channels never fire
        counter = 64'd49;
        wr(0, 64'd50, 1'b1);
        wr(3, 64'd50, 1'b1);
        tick_at(64'd50);
        check("prio_ring", {63'd0, ring}, 64'd1);
        check("prio_id", {62'd0, ring_id}, 64'd0);
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        check("cancel_active", {63'd0, active}, 64'd0);
        check("cancel_ring", {63'd0, ring}, 64'd0);
        wr(0, 64'd50, 1'b0);
        wr(3, 64'd50, 1'b0);
        tick_at(64'd50);
        check("dis_ring", {63'd0, ring}, 64'd0);
        check("dis_active", {63'd0, active}, 64'd0);

        // snooze two ticks into ON, 300 silent ticks, then three full bursts
        wr(1, 64'd200, 1'b1);
        tick_at(64'd200);
        check("sn_id", {62'd0, ring_id}, 64'd1);
        tick_at(64'd201);
        tick_at(64'd202);
        check("sn_pre_ring", {63'd0, ring}, 64'd1);
        snooze = 1'b1;
        cyc();
        snooze = 1'b0;
        check("sn_ring", {63'd0, ring}, 64'd0);
        check("sn_active", {63'd0, active}, 64'd1);
        for (int s = 1; s <= 300; s++) begin
            tick_at(64'(202 + s));
            check("sn_wait_ring", {63'd0, ring}, {63'd0, (s == 300)});
        end
        burst_pattern(64'd502, "sn_burst");

        // cancel beats a simultaneous match
        wr(2, 64'd1000, 1'b1);
        wr(1, 64'd1003, 1'b1);
        tick_at(64'd1000);
        check("cm_id", {62'd0, ring_id}, 64'd2);
        tick_at(64'd1001);
        tick_at(64'd1002);
        cancel = 1'b1;
        tick_at(64'd1003);
        cancel = 1'b0;
        check("cm_ring", {63'd0, ring}, 64'd0);
        check("cm_active", {63'd0, active}, 64'd0);
        tick_at(64'd1004);
        check("cm_stay_idle", {63'd0, active}, 64'd0);

        // clearing the ringing channel stops it; clearing another does not
        wr(2, 64'd1010, 1'b1);
        tick_at(64'd1010);
        check("clr_pre_active", {63'd0, active}, 64'd1);
        sel = 2'd3; clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("clr_other_active", {63'd0, active}, 64'd1);
        sel = 2'd2; clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("clr_own_active", {63'd0, active}, 64'd0);
        check("clr_own_ring", {63'd0, ring}, 64'd0);

        // writing set_en=0 to the ringing channel stops it
        wr(1, 64'd1020, 1'b1);
        tick_at(64'd1020);
        check("den_id", {62'd0, ring_id}, 64'd1);
        wr(1, 64'd1020, 1'b0);
        check("den_active", {63'd0, active}, 64'd0);

        // reset for one edge mid-ON
        wr(0, 64'd2000, 1'b1);
        tick_at(64'd2000);
        check("mid_ring", {63'd0, ring}, 64'd1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("mr_ring", {63'd0, ring}, 64'd0);
        check("mr_active", {63'd0, active}, 64'd0);
        check("mr_id", {62'd0, ring_id}, 64'd0);
        cyc();
        check("mr_stamp", sel_stamp, 64'd0);
        check("mr_en", {63'd0, sel_en}, 64'd0);

        // set and clear on the same edge zero the channel
        wr(1, 64'd55, 1'b1);
        cyc();
        check("sc_pre_stamp", sel_stamp, 64'd55);
        check("sc_pre_stamp3", sel_stamp3, 64'd55);
        sel = 2'd1; set_stamp = 64'd77; set_en = 1'b1; set = 1'b1; clear = 1'b1;
        cyc();
        set = 1'b0; clear = 1'b0;
        cyc();
        check("sc_stamp", sel_stamp, 64'd0);
        check("sc_en", {63'd0, sel_en}, 64'd0);
        check("sc_stamp3", sel_stamp3, 64'd0);

        // sel=3 is a real channel in the 4-channel build, out of range in the 3-channel one
        wr(3, 64'd99, 1'b1);
        cyc();
        check("ch3_stamp", sel_stamp, 64'd99);
        check("ch3_en", {63'd0, sel_en}, 64'd1);
        check("oor_stamp3", sel_stamp3, 64'd0);
        check("oor_en3", {63'd0, sel_en3}, 64'd0);
        for (int c = 0; c < 3; c++) begin
            sel = 2'(c);
            cyc();
            check("oor_nochange3", sel_stamp3, 64'd0);
            check("oor_nochange_en3", {63'd0, sel_en3}, 64'd0);
        end
        check("n3_ring", {63'd0, ring3}, 64'd0);
        check("n3_active", {63'd0, active3}, 64'd0);
        check("n3_id", {62'd0, ring_id3}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
